// File: rtl/axi_read_master_if.sv
// axi_read_master_if: command, AXI AR/R and user data-out signals of axi_read_master
// master modport is the initiator side; slave modport is the fabric/user side.
interface axi_read_master_if #(
    parameter int AXI_IW = 4,
    parameter int AXI_AW = 32,
    parameter int AXI_DW = 64,
    parameter int AXI_LW = 8,
    parameter int CMD_LW = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [AXI_AW-1:0] cmd_addr;
    logic [CMD_LW-1:0] cmd_len;
    logic [AXI_IW-1:0] cmd_id;
    logic [AXI_IW-1:0] ARID;
    logic [AXI_AW-1:0] ARADDR;
    logic [AXI_LW-1:0] ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic              ARVALID;
    logic              ARREADY;
    logic [3:0]        ARCACHE;
    logic [2:0]        ARPROT;
    logic [3:0]        ARQOS;
    logic [3:0]        ARREGION;
    logic [AXI_IW-1:0] RID;
    logic [AXI_DW-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;
    logic [AXI_DW-1:0] dout_data;
    logic              dout_valid;
    logic              dout_ready;
    logic              dout_last;
    logic              done;
    logic              err;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, cmd_id, ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID, dout_ready,
        output cmd_ready, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARCACHE, ARPROT, ARQOS, ARREGION, RREADY,
        output dout_data, dout_valid, dout_last, done, err
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, cmd_id, ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID, dout_ready,
        input  cmd_ready, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARCACHE, ARPROT, ARQOS, ARREGION, RREADY,
        input  dout_data, dout_valid, dout_last, done, err
    );
endinterface

// File: rtl/axi_read_master.sv
// axi_read_master: AXI4 read initiator splitting a command into 4KB-safe INCR bursts.
// Define AXIM_RCHK_EN to add RLAST-vs-ARLEN and RID checking into err.
module axi_read_master #(
    parameter int AXI_IW = 4,
    parameter int AXI_AW = 32,
    parameter int AXI_DW = 64,
    parameter int AXI_LW = 8,
    parameter int CMD_LW = 16
) (
    input logic ACLK,
    input logic ARESET,
    axi_read_master_if.master bus
);
    localparam int SZ = $clog2(AXI_DW / 8);
    localparam int CW = CMD_LW + 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t            state;
    logic [AXI_AW-1:0] addr;
    logic [AXI_AW-1:0] a_in;
    logic [AXI_AW-1:0] nxt_addr;
    logic [CW-1:0]     rem;
    logic [CW-1:0]     r_in;
    logic [31:0]       b_4k;
    logic [31:0]       b_max;
    logic [31:0]       beats;
    logic [AXI_LW-1:0] len;
    logic              r_hs;
    logic              b_end;
    logic              b_err;

    // Sizing inputs: the new command in IDLE, otherwise the continuation after the current beat
    assign a_in     = (state == IDLE) ? (bus.cmd_addr & ~AXI_AW'((1 << SZ) - 1)) : addr;
    assign r_in     = (state == IDLE) ? CW'(bus.cmd_len) + CW'(1) : rem - CW'(1);
    assign b_4k     = (32'd4096 - 32'(a_in[11:0])) >> SZ;
    assign b_max    = 32'd1 << AXI_LW;
    assign len      = AXI_LW'(beats - 32'd1);
    assign nxt_addr = a_in + AXI_AW'(beats << SZ);

    always_comb begin
        beats = 32'(r_in);
        beats = (b_max < beats) ? b_max : beats;
        beats = (b_4k < beats) ? b_4k : beats;
    end

    assign r_hs           = bus.RVALID && bus.RREADY;
    assign bus.RREADY     = (state == DATA) && bus.dout_ready;
    assign bus.dout_valid = (state == DATA) && bus.RVALID;
    assign bus.dout_data  = bus.RDATA;
    assign bus.dout_last  = bus.dout_valid && bus.RLAST && (rem == CW'(1));
    assign bus.ARSIZE     = 3'(SZ);
    assign bus.ARBURST    = 2'b01;
    assign bus.ARCACHE    = 4'b0011;
    assign bus.ARPROT     = 3'b000;
    assign bus.ARQOS      = 4'd0;
    assign bus.ARREGION   = 4'd0;

`ifdef AXIM_RCHK_EN
    logic [AXI_LW-1:0] bcnt;
    logic              unused;

    // bcnt counts down the beats still owed in the current burst
    assign b_end  = bus.RLAST || (bcnt == '0);
    assign b_err  = bus.RRESP[1] || (bus.RLAST != (bcnt == '0)) || (bus.RID != bus.ARID);
    assign unused = bus.RRESP[0];

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)
            bcnt <= '0;
        else if (state == ADDR && bus.ARREADY)
            bcnt <= bus.ARLEN;
        else if (r_hs)
            bcnt <= bcnt - AXI_LW'(1);
    end
`else
    logic unused;

    assign b_end  = bus.RLAST;
    assign b_err  = bus.RRESP[1];
    assign unused = ^{bus.RID, bus.RRESP[0]};
`endif

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state         <= IDLE;
            bus.cmd_ready <= 1'b0;
            bus.ARVALID   <= 1'b0;
            bus.ARADDR    <= '0;
            bus.ARLEN     <= '0;
            bus.ARID      <= '0;
            addr          <= '0;
            rem           <= '0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    bus.cmd_ready <= 1'b1;
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        bus.cmd_ready <= 1'b0;
                        bus.err       <= 1'b0;
                        bus.ARID      <= bus.cmd_id;
                        bus.ARVALID   <= 1'b1;
                        bus.ARADDR    <= a_in;
                        bus.ARLEN     <= len;
                        addr          <= nxt_addr;
                        rem           <= r_in;
                        state         <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus.ARREADY) begin
                        bus.ARVALID <= 1'b0;
                        state       <= DATA;
                    end
                end
                DATA: begin
                    if (r_hs) begin
                        rem <= r_in;
                        if (b_err)
                            bus.err <= 1'b1;
                        if (b_end && r_in != '0) begin
                            bus.ARVALID <= 1'b1;
                            bus.ARADDR  <= a_in;
                            bus.ARLEN   <= len;
                            addr        <= nxt_addr;
                            state       <= ADDR;
                        end else if (b_end) begin
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    bus.cmd_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
